// File: rtl/tcam_search_engine.sv
// Ternary CAM with stored and per-search don't-care masks, feeding a two-stage
// search pipeline (match vector, then priority encode and popcount) with valid/ready on both ends.
module tcam_search_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_inval,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [WIDTH-1:0] srch_key,
  input  logic [WIDTH-1:0] srch_mask,
  output logic             rslt_valid,
  input  logic             rslt_ready,
  output logic             rslt_hit,
  output logic [AW-1:0]    rslt_addr,
  output logic [DEPTH-1:0] rslt_match_vec,
  output logic [AW:0]      rslt_count
);

  logic [WIDTH-1:0] row_data [DEPTH];
  logic [WIDTH-1:0] row_mask [DEPTH];
  logic [DEPTH-1:0] row_valid;

  logic             s1_valid;
  logic [DEPTH-1:0] s1_vec;
  logic [DEPTH-1:0] match_vec;
  logic [AW-1:0]    enc_addr;
  logic [AW:0]      enc_count;
  logic             accept;
  logic             out_load;

  assign out_load   = !rslt_valid || rslt_ready;
  assign srch_ready = !s1_valid || !rslt_valid || rslt_ready;
  assign accept     = srch_valid && srch_ready;

  // Addresses at or beyond DEPTH never compare equal to a row index, so they are dropped.
  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_en && !wr_inval && wr_addr == AW'(r)) begin
        row_data[r] <= wr_data;
        row_mask[r] <= wr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_en && wr_addr == AW'(r)) begin
          row_valid[r] <= !wr_inval;
        end
      end
    end
  end

  always_comb begin
    match_vec = '0;
    for (int r = 0; r < DEPTH; r++) begin
      match_vec[r] = row_valid[r] && (&(srch_mask | row_mask[r] | ~(srch_key ^ row_data[r])));
    end
  end

  // Scanning downward leaves the lowest set index in enc_addr.
  always_comb begin
    enc_addr  = '0;
    enc_count = '0;
    for (int r = DEPTH - 1; r >= 0; r--) begin
      if (s1_vec[r]) begin
        enc_addr = AW'(r);
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      enc_count = enc_count + (AW + 1)'(s1_vec[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_vec <= match_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      rslt_valid     <= 1'b0;
      rslt_hit       <= 1'b0;
      rslt_addr      <= '0;
      rslt_match_vec <= '0;
      rslt_count     <= '0;
    end else begin
      if (out_load) begin
        rslt_valid <= s1_valid;
        if (s1_valid) begin
          rslt_hit       <= |s1_vec;
          rslt_addr      <= enc_addr;
          rslt_match_vec <= s1_vec;
          rslt_count     <= enc_count;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (out_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcam_search_engine.sv
// Scoreboard bench for tcam_search_engine: directed scenarios followed by randomized
// traffic, all results checked against an array-based model of the CAM.
module tb_tcam_search_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             wr_inval = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] wr_mask = '0;
  logic             srch_valid = 1'b0;
  logic             srch_ready;
  logic [WIDTH-1:0] srch_key = '0;
  logic [WIDTH-1:0] srch_mask = '0;
  logic             rslt_valid;
  logic             rslt_ready = 1'b1;
  logic             rslt_hit;
  logic [AW-1:0]    rslt_addr;
  logic [DEPTH-1:0] rslt_match_vec;
  logic [AW:0]      rslt_count;

  always #5 clk = ~clk;

  tcam_search_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_inval(wr_inval), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key), .srch_mask(srch_mask),
    .rslt_valid(rslt_valid), .rslt_ready(rslt_ready), .rslt_hit(rslt_hit), .rslt_addr(rslt_addr),
    .rslt_match_vec(rslt_match_vec), .rslt_count(rslt_count)
  );

  typedef struct {
    logic [DEPTH-1:0] vec;
    logic             hit;
    logic [AW-1:0]    addr;
    logic [AW:0]      cnt;
    int               acc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t sb[$];

  logic [WIDTH-1:0] m_data  [DEPTH];
  logic [WIDTH-1:0] m_mask  [DEPTH];
  logic             m_valid [DEPTH];

  logic             stall_prev = 1'b0;
  logic             snap_hit;
  logic [AW-1:0]    snap_addr;
  logic [DEPTH-1:0] snap_vec;
  logic [AW:0]      snap_cnt;

  function automatic exp_t model_search(logic [WIDTH-1:0] key, logic [WIDTH-1:0] sm);
    exp_t e;
    int   rows[$];
    for (int r = 0; r < DEPTH; r++) begin
      if (m_valid[r] && (((key ^ m_data[r]) & ~(sm | m_mask[r])) == '0)) rows.push_back(r);
    end
    e.vec = '0;
    foreach (rows[i]) e.vec[rows[i]] = 1'b1;
    e.hit  = rows.size() > 0;
    e.addr = (rows.size() > 0) ? AW'(rows[0]) : '0;
    e.cnt  = (AW + 1)'(rows.size());
    e.acc  = cycle;
    return e;
  endfunction

  // Model and monitor share one negedge process: check what the DUT presents, then record new traffic.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    cycle++;
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        m_valid[r] = 1'b0;
        m_data[r]  = '0;
        m_mask[r]  = '0;
      end
    end else begin
      exp_ready = (sb.size() < 2) || rslt_ready;
      checks++;
      if (srch_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL srch_ready: got %0b, required %0b (in flight %0d)", srch_ready, exp_ready, sb.size());
      end
      if (stall_prev) begin
        checks++;
        if (!rslt_valid || rslt_hit !== snap_hit || rslt_addr !== snap_addr ||
            rslt_match_vec !== snap_vec || rslt_count !== snap_cnt) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%0b hit=%0b addr=%0d vec=%h cnt=%0d, required held hit=%0b addr=%0d vec=%h cnt=%0d",
                   rslt_valid, rslt_hit, rslt_addr, rslt_match_vec, rslt_count, snap_hit, snap_addr, snap_vec, snap_cnt);
        end
      end
      if (sb.size() > 0 && cycle >= sb[0].acc + 2) begin
        checks++;
        if (rslt_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL latency: rslt_valid=%0b, required 1 (accepted cycle %0d, now %0d)", rslt_valid, sb[0].acc, cycle);
        end
      end
      if (rslt_valid && rslt_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got vec=%h, required no result", rslt_match_vec);
        end else begin
          e = sb.pop_front();
          if (rslt_hit !== e.hit || rslt_addr !== e.addr || rslt_match_vec !== e.vec || rslt_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL result: got hit=%0b addr=%0d vec=%h cnt=%0d, required hit=%0b addr=%0d vec=%h cnt=%0d",
                     rslt_hit, rslt_addr, rslt_match_vec, rslt_count, e.hit, e.addr, e.vec, e.cnt);
          end
        end
      end
      stall_prev = rslt_valid && !rslt_ready;
      snap_hit   = rslt_hit;
      snap_addr  = rslt_addr;
      snap_vec   = rslt_match_vec;
      snap_cnt   = rslt_count;
      if (srch_valid && srch_ready) sb.push_back(model_search(srch_key, srch_mask));
      if (wr_en && int'(wr_addr) < DEPTH) begin
        m_valid[wr_addr] = !wr_inval;
        if (!wr_inval) begin
          m_data[wr_addr] = wr_data;
          m_mask[wr_addr] = wr_mask;
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    wr_en = 1'b0;
    srch_valid = 1'b0;
    rslt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic inv, input logic [AW-1:0] wa,
                               input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] wm,
                               input logic sv, input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] sm);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    wr_en = we; wr_inval = inv; wr_addr = wa; wr_data = wd; wr_mask = wm;
    srch_valid = sv; srch_key = key; srch_mask = sm;
    do begin
      @(negedge clk);
      acc = srch_ready;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      n++;
    end while (sv && !acc && n < 50);
    if (sv && !acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: srch_ready stayed 0, required acceptance within 50 cycles");
    end
    srch_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic eh, input logic [AW-1:0] ea,
                             input logic [DEPTH-1:0] evec, input logic [AW:0] ec, input logic erdy);
    checks++;
    if (rslt_valid !== ev || rslt_hit !== eh || rslt_addr !== ea || rslt_match_vec !== evec ||
        rslt_count !== ec || srch_ready !== erdy) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b hit=%0b addr=%0d vec=%h cnt=%0d ready=%0b, required valid=%0b hit=%0b addr=%0d vec=%h cnt=%0d ready=%0b",
               name, rslt_valid, rslt_hit, rslt_addr, rslt_match_vec, rslt_count, srch_ready,
               ev, eh, ea, evec, ec, erdy);
    end
  endtask

  initial begin
    int n;
    int row;
    doReset();
    @(negedge clk);
    checkOutput("reset_state", 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);
    @(posedge clk); #1;

    $display("[TB] scenario 1: stored mask");
    applyStimulus(1, 0, 3'd0, 8'h01, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd4, 8'h11, 8'h01, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h10, 8'h00);
    @(posedge clk); #1;
    checkOutput("stored_mask_hit", 1'b1, 1'b1, 3'd4, 8'h10, 4'd1, 1'b1);

    $display("[TB] scenario 2: multi-hit and search mask");
    doReset();
    applyStimulus(1, 0, 3'd1, 8'h11, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd2, 8'h11, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd4, 8'h11, 8'h01, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h11, 8'h00);
    @(posedge clk); #1;
    checkOutput("multi_hit", 1'b1, 1'b1, 3'd1, 8'h16, 4'd3, 1'b1);
    applyStimulus(1, 0, 3'd0, 8'h01, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h11, 8'hF0);
    @(posedge clk); #1;
    checkOutput("search_mask_hit", 1'b1, 1'b1, 3'd0, 8'h17, 4'd4, 1'b1);

    $display("[TB] scenario 3: empty and invalidated rows");
    doReset();
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checkOutput("empty_miss", 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);
    applyStimulus(1, 0, 3'd0, 8'h01, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h01, 8'h00);
    @(posedge clk); #1;
    checkOutput("invalidated_miss", 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);

    $display("[TB] scenario 4: write and search in the same cycle");
    doReset();
    applyStimulus(1, 0, 3'd3, 8'h33, 8'h00, 1, 8'h33, 8'h00);
    @(posedge clk); #1;
    checkOutput("same_cycle_miss", 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h33, 8'h00);
    @(posedge clk); #1;
    checkOutput("next_cycle_hit", 1'b1, 1'b1, 3'd3, 8'h08, 4'd1, 1'b1);

    $display("[TB] scenario 5: backpressure");
    doReset();
    applyStimulus(1, 0, 3'd0, 8'hA0, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd1, 8'hB0, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd2, 8'hC0, 8'h00, 0, 8'h00, 8'h00);
    rslt_ready = 1'b0;
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'hA0, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'hB0, 8'h00);
    srch_valid = 1'b1;
    srch_key   = 8'hC0;
    @(negedge clk);
    checkOutput("stall_full_a", 1'b1, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stall_hold_a", 1'b1, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0);
    @(posedge clk); #1;
    rslt_ready = 1'b1;
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'hC0, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] scenario 6: reset mid-flight");
    doReset();
    applyStimulus(1, 0, 3'd5, 8'h55, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 3'd6, 8'h66, 8'h0F, 0, 8'h00, 8'h00);
    rslt_ready = 1'b0;
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h55, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h66, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rslt_ready = 1'b1;
    checkOutput("midflight_reset", 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h55, 8'h00);
    @(posedge clk); #1;
    checkOutput("post_reset_miss", 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1);

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 800; i++) begin
      row        = int'($urandom_range(DEPTH - 1));
      wr_en      = ($urandom_range(3) == 0);
      wr_inval   = ($urandom_range(7) == 0);
      wr_addr    = AW'($urandom_range(DEPTH - 1));
      wr_data    = WIDTH'($urandom);
      wr_mask    = WIDTH'($urandom & $urandom & $urandom);
      srch_valid = ($urandom_range(2) != 0);
      srch_key   = ($urandom_range(3) != 0) ? m_data[row] ^ WIDTH'($urandom & $urandom & $urandom & $urandom) : WIDTH'($urandom);
      srch_mask  = ($urandom_range(3) == 0) ? WIDTH'($urandom & $urandom) : '0;
      rslt_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    srch_valid = 1'b0;
    rslt_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rslt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_valid: got rslt_valid=%0b, required 0", rslt_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
